// File: rtl/usb_buf_pkg.sv
// rtl/usb_buf_pkg.sv - shared sizing constants and types for the USB data buffer
package usb_buf_pkg;
    localparam int BUF_DEPTH  = 64;
    localparam int BUF_ADDR_W = 6;
    localparam int BUF_OCC_W  = 7;

    typedef logic [7:0] byte_t;
endpackage

// File: rtl/usb_buffer_ram.sv
// rtl/usb_buffer_ram.sv - byte storage array, synchronous write, combinational read
module usb_buffer_ram
    import usb_buf_pkg::*;
#(
    parameter int DEPTH  = BUF_DEPTH,
    parameter int ADDR_W = BUF_ADDR_W
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  byte_t             wdata,
    input  logic [ADDR_W-1:0] raddr,
    output byte_t             rdata
);

    byte_t mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/usb_data_buffer.sv
// rtl/usb_data_buffer.sv - 64-byte FIFO shared by the AHB slave and the USB packet engines
module usb_data_buffer
    import usb_buf_pkg::*;
#(
    parameter int DEPTH  = BUF_DEPTH,
    parameter int ADDR_W = BUF_ADDR_W,
    parameter int OCC_W  = BUF_OCC_W
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             clear,
    input  logic             store_tx_data,
    input  logic [7:0]       tx_data,
    input  logic             get_rx_data,
    output logic [7:0]       rx_data,
    input  logic             store_rx_packet_data,
    input  logic [7:0]       rx_packet_data,
    input  logic             get_tx_packet_data,
    output logic [7:0]       tx_packet_data,
    output logic [OCC_W-1:0] buffer_occupancy
);

    logic [ADDR_W-1:0] wptr;
    logic [ADDR_W-1:0] rptr;
    logic              full;
    logic              empty;
    logic              push_req;
    logic              pop_req;
    logic              push_acc;
    logic              pop_acc;
    logic              ram_we;
    byte_t             push_data;
    byte_t             rdata;

    assign full  = (buffer_occupancy == OCC_W'(DEPTH));
    assign empty = (buffer_occupancy == '0);

    // USB engines win both collisions; the AHB side is the lower-priority requester.
    assign push_req  = store_rx_packet_data | store_tx_data;
    assign pop_req   = get_tx_packet_data | get_rx_data;
    assign push_data = store_rx_packet_data ? rx_packet_data : tx_data;

    // Gating uses pre-edge occupancy, so a full FIFO still pops and an empty one never falls through.
    assign push_acc = push_req & ~full;
    assign pop_acc  = pop_req & ~empty;

    // Reset and clear discard same-cycle pushes, so the array is left untouched too.
    assign ram_we = push_acc & n_rst & ~clear;

    usb_buffer_ram #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (wptr),
        .wdata (push_data),
        .raddr (rptr),
        .rdata (rdata)
    );

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            wptr             <= '0;
            rptr             <= '0;
            buffer_occupancy <= '0;
            rx_data          <= '0;
            tx_packet_data   <= '0;
        end else if (clear) begin
            wptr             <= '0;
            rptr             <= '0;
            buffer_occupancy <= '0;
        end else begin
            if (push_acc) begin
                wptr <= wptr + 1'b1;
            end
            if (pop_acc) begin
                rptr <= rptr + 1'b1;
                if (get_tx_packet_data) begin
                    tx_packet_data <= rdata;
                end else begin
                    rx_data <= rdata;
                end
            end
            case ({push_acc, pop_acc})
                2'b10:   buffer_occupancy <= buffer_occupancy + 1'b1;
                2'b01:   buffer_occupancy <= buffer_occupancy - 1'b1;
                default: buffer_occupancy <= buffer_occupancy;
            endcase
        end
    end

endmodule
